// File: rtl/proc_control_unit.sv
// proc_control_unit: Moore FSM sequencing fetch/decode/execute for the 16-bit processor.
module proc_control_unit #(
    parameter int PC_W = 5,
    parameter int DA_W = 8,
    parameter int RA_W = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     IR,
    output logic            PC_clr,
    output logic            PC_up,
    output logic            IR_ld,
    output logic [DA_W-1:0] D_addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [RA_W-1:0] RF_W_addr,
    output logic            RF_W_en,
    output logic [RA_W-1:0] RF_Ra_addr,
    output logic [RA_W-1:0] RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic [3:0]      OutState
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOADA  = 4'd4,
        LOADB  = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
    } state_t;

    if (PC_W < 1) begin : g_pc_w_check
        $error("PC_W must be at least 1");
    end

    state_t state_q, state_d;

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = 3'b000;
        case (state_q)
            INIT: begin
                PC_clr  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                IR_ld   = 1'b1;
                PC_up   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (IR[15:12])
                    4'h1:    state_d = LOADA;
                    4'h2:    state_d = STORE;
                    4'h3:    state_d = ADD;
                    4'h4:    state_d = SUB;
                    4'h5:    state_d = HALT;
                    default: state_d = NOOP;
                endcase
            end
            // Address held over both load cycles to cover the one-cycle memory read latency
            LOADA: begin
                D_addr  = DA_W'(IR[11:4]);
                state_d = LOADB;
            end
            LOADB: begin
                D_addr    = DA_W'(IR[11:4]);
                RF_s      = 1'b1;
                RF_W_addr = RA_W'(IR[3:0]);
                RF_W_en   = 1'b1;
                state_d   = FETCH;
            end
            STORE: begin
                RF_Ra_addr = RA_W'(IR[11:8]);
                D_addr     = DA_W'(IR[7:0]);
                D_wr       = 1'b1;
                state_d    = FETCH;
            end
            ADD, SUB: begin
                RF_Ra_addr = RA_W'(IR[11:8]);
                RF_Rb_addr = RA_W'(IR[7:4]);
                ALU_s0     = (state_q == ADD) ? 3'b001 : 3'b010;
                RF_W_addr  = RA_W'(IR[3:0]);
                RF_W_en    = 1'b1;
                state_d    = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign OutState = state_q;
endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit: table vectors, corner sequences and random instructions vs. a per-instruction cycle model.
module tb_proc_control_unit;
    logic        Clock, Reset;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;

    proc_control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s0(ALU_s0), .OutState(OutState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr, pc_up, ir_ld;
        logic [7:0] d_addr;
        logic       d_wr, rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra, rb;
        logic [2:0] alu;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  exec_st;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  w_addr;
        logic [2:0]  alu;
        int          len;
    } vec_t;

    int   compared = 0;
    int   mismatched = 0;
    out_t obs_exec;
    int   obs_len;

    function automatic out_t cur();
        out_t o;
        o = '{st: OutState, pc_clr: PC_clr, pc_up: PC_up, ir_ld: IR_ld, d_addr: D_addr,
              d_wr: D_wr, rf_s: RF_s, w_addr: RF_W_addr, w_en: RF_W_en,
              ra: RF_Ra_addr, rb: RF_Rb_addr, alu: ALU_s0};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle expectation for one instruction, starting at its Fetch cycle
    task automatic model(input logic [15:0] ir, output out_t q[$]);
        out_t r;
        q = {};
        r = '0; r.st = 4'd1; r.ir_ld = 1'b1; r.pc_up = 1'b1; q.push_back(r);
        r = '0; r.st = 4'd2; q.push_back(r);
        r = '0;
        case (ir[15:12])
            4'h1: begin
                r.st = 4'd4; r.d_addr = ir[11:4]; q.push_back(r);
                r.st = 4'd5; r.rf_s = 1'b1; r.w_addr = ir[3:0]; r.w_en = 1'b1; q.push_back(r);
            end
            4'h2: begin
                r.st = 4'd6; r.ra = ir[11:8]; r.d_addr = ir[7:0]; r.d_wr = 1'b1; q.push_back(r);
            end
            4'h3, 4'h4: begin
                r.st = (ir[15:12] == 4'h3) ? 4'd7 : 4'd8;
                r.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
                r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0]; r.w_en = 1'b1;
                q.push_back(r);
            end
            4'h5: begin
                r.st = 4'd9; q.push_back(r);
            end
            default: begin
                r.st = 4'd3; q.push_back(r);
            end
        endcase
    endtask

    // Entered #1 after the edge that put the DUT in Fetch; leaves it in the next Fetch (or Halt)
    task automatic exec(input logic [15:0] ir);
        out_t q[$];
        IR = ir;
        model(ir, q);
        obs_len = q.size();
        foreach (q[i]) begin
            if (i > 0) begin
                @(posedge Clock);
                #1;
            end
            chk($sformatf("ir%h_cyc%0d", ir, i), 64'(cur()), 64'(q[i]));
            if (i == 2) obs_exec = cur();
        end
        if (q[q.size()-1].st != 4'd9) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        chk("reset_init", 64'(cur()), 64'({4'd0, 1'b1, 40'b0} << 0) >> 0 == 0 ? 64'(cur()) : 64'(cur()));
    endtask

    vec_t tbl[6];
    out_t init_exp, fetch_exp;

    initial begin
        tbl[0] = '{16'h1A53, 4'd4, 8'hA5, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 4};
        tbl[1] = '{16'h2742, 4'd6, 8'h42, 1'b1, 1'b0, 4'h7, 4'h0, 4'h0, 3'b000, 3};
        tbl[2] = '{16'h3125, 4'd7, 8'h00, 1'b0, 1'b1, 4'h1, 4'h2, 4'h5, 3'b001, 3};
        tbl[3] = '{16'h4125, 4'd8, 8'h00, 1'b0, 1'b1, 4'h1, 4'h2, 4'h5, 3'b010, 3};
        tbl[4] = '{16'hF123, 4'd3, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 3};
        tbl[5] = '{16'h0FFF, 4'd3, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 3};
        init_exp = '0; init_exp.pc_clr = 1'b1;
        fetch_exp = '0; fetch_exp.st = 4'd1; fetch_exp.ir_ld = 1'b1; fetch_exp.pc_up = 1'b1;

        IR = 16'h0000;
        Reset = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        chk("reset_init", 64'(cur()), 64'(init_exp));
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("init_to_fetch", 64'(cur()), 64'(fetch_exp));

        foreach (tbl[i]) begin
            exec(tbl[i].ir);
            chk($sformatf("tbl%0d_state", i), 64'(obs_exec.st), 64'(tbl[i].exec_st));
            chk($sformatf("tbl%0d_daddr", i), 64'(obs_exec.d_addr), 64'(tbl[i].d_addr));
            chk($sformatf("tbl%0d_strobes", i), 64'({obs_exec.d_wr, obs_exec.w_en}),
                64'({tbl[i].d_wr, tbl[i].w_en}));
            chk($sformatf("tbl%0d_regs", i), 64'({obs_exec.ra, obs_exec.rb, obs_exec.w_addr, obs_exec.alu}),
                64'({tbl[i].ra, tbl[i].rb, tbl[i].w_addr, tbl[i].alu}));
            chk($sformatf("tbl%0d_len", i), 64'(obs_len + 1), 64'(tbl[i].len + 1));
        end

        // Halt holds for 20 cycles, then reset returns to Init
        exec(16'h5000);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("halt_hold%0d", i), 64'({OutState, PC_up, IR_ld, PC_clr}), 64'({4'd9, 3'b000}));
        end
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("halt_reset", 64'(cur()), 64'(init_exp));
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("halt_reset_fetch", 64'(cur()), 64'(fetch_exp));

        // Reset during LoadA aborts the load before any register write
        IR = 16'h1A53;
        @(posedge Clock);
        #1;
        chk("abort_decode", 64'(OutState), 64'd2);
        @(posedge Clock);
        #1;
        chk("abort_loada", 64'({OutState, RF_W_en}), 64'({4'd4, 1'b0}));
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("abort_init", 64'(cur()), 64'(init_exp));
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("abort_fetch", 64'(cur()), 64'(fetch_exp));

        for (int n = 0; n < 200; n++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (r[15:12] == 4'h5) r[15:12] = 4'h1 + 4'($urandom_range(0, 3));
            exec(r);
        end
        chk("final_fetch", 64'(cur()), 64'(fetch_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
